// File: rtl/intersection_pkg.sv
// Shared types and lamp encodings for the intersection right-of-way arbiter.
package intersection_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority search over approach requests, starting just after ptr.
module rr_picker #(
    parameter int N_APP = 4
) (
    input  logic [N_APP-1:0]         req,
    input  logic [$clog2(N_APP)-1:0] ptr,
    output logic                     any,
    output logic [$clog2(N_APP)-1:0] winner
);

    localparam int ID_W = $clog2(N_APP);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate down to ptr+1 so the nearest hit wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N_APP; k >= 1; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_APP);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/intersection_arbiter.sv
// Round-robin right-of-way arbiter with min/max green, yellow, all-red clearance
// and emergency preemption; drives one 3-bit lamp code per approach.
module intersection_arbiter
    import intersection_pkg::*;
#(
    parameter int N_APP     = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW    = 3,
    parameter int ALLRED    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic [N_APP-1:0]         sensor,
    input  logic                     preempt,
    input  logic [$clog2(N_APP)-1:0] preempt_id,
    output logic [3*N_APP-1:0]       light,
    output logic [$clog2(N_APP)-1:0] active_id,
    output logic                     in_preempt
);

    localparam int ID_W = $clog2(N_APP);

    if (N_APP < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW < 1 || ALLRED < 1 ||
        GREEN_MAX >= (1 << CNT_W) || YELLOW >= (1 << CNT_W) || ALLRED >= (1 << CNT_W))
    begin : g_bad_params
        $error("intersection_arbiter: illegal timing parameters");
    end

    state_e             state, state_n;
    logic [CNT_W-1:0]   timer, timer_n;
    logic [CNT_W-1:0]   elapsed, elapsed_n, el_inc;
    logic [ID_W-1:0]    rr_ptr, rr_n, active_n;
    logic               inp_n;
    logic [N_APP-1:0]   others_req;
    logic               others_any, own_req;
    logic               rr_any;
    logic [ID_W-1:0]    rr_win;
    logic [3*N_APP-1:0] light_n;

    rr_picker #(.N_APP(N_APP)) u_rr (
        .req    (sensor),
        .ptr    (rr_ptr),
        .any    (rr_any),
        .winner (rr_win)
    );

    always_comb begin
        others_req = sensor;
        for (int i = 0; i < N_APP; i++)
            if (active_id == ID_W'(i)) others_req[i] = 1'b0;
        others_any = |others_req;
        own_req    = sensor[active_id];
        el_inc     = (elapsed == '1) ? elapsed : elapsed + 1'b1;
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        elapsed_n = elapsed;
        active_n  = active_id;
        rr_n      = rr_ptr;
        inp_n     = in_preempt & preempt;
        case (state)
            ST_ALLRED: begin
                if (tick) begin
                    if (timer <= CNT_W'(1)) begin
                        state_n   = ST_GREEN;
                        elapsed_n = '0;
                        if (preempt) begin
                            active_n = preempt_id;
                            inp_n    = 1'b1;
                        end else if (rr_any) begin
                            active_n = rr_win;
                            rr_n     = rr_win;
                            inp_n    = 1'b0;
                        end else begin
                            active_n = '0;
                            inp_n    = 1'b0;
                        end
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
            end
            ST_GREEN: begin
                // Preemption for a different approach leaves green at once, tick or not.
                if (preempt && preempt_id != active_id) begin
                    state_n = ST_YELLOW;
                    timer_n = CNT_W'(YELLOW);
                end else if (tick) begin
                    elapsed_n = el_inc;
                    if (!preempt && others_any && el_inc >= CNT_W'(GREEN_MIN) &&
                        (!own_req || el_inc >= CNT_W'(GREEN_MAX))) begin
                        state_n = ST_YELLOW;
                        timer_n = CNT_W'(YELLOW);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (timer <= CNT_W'(1)) begin
                        state_n = ST_ALLRED;
                        timer_n = CNT_W'(ALLRED);
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_ALLRED;
                timer_n = CNT_W'(ALLRED);
            end
        endcase
    end

    // Lamps are decoded from next-state so they change on the same edge as the FSM.
    always_comb begin
        light_n = {N_APP{LIGHT_RED}};
        for (int i = 0; i < N_APP; i++) begin
            if (active_n == ID_W'(i)) begin
                if (state_n == ST_GREEN)       light_n[3*i +: 3] = LIGHT_GRN;
                else if (state_n == ST_YELLOW) light_n[3*i +: 3] = LIGHT_YEL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ALLRED;
            timer      <= CNT_W'(ALLRED);
            elapsed    <= '0;
            active_id  <= '0;
            rr_ptr     <= '0;
            in_preempt <= 1'b0;
            light      <= {N_APP{LIGHT_RED}};
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            elapsed    <= elapsed_n;
            active_id  <= active_n;
            rr_ptr     <= rr_n;
            in_preempt <= inp_n;
            light      <= light_n;
        end
    end

endmodule
